// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM state type and CombCalc opcode encodings.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD_AB = 3'b000;
    localparam logic [2:0] OP_SUB_AB = 3'b001;
    localparam logic [2:0] OP_ABS_B  = 3'b010;
    localparam logic [2:0] OP_ADD_BA = 3'b100;
    localparam logic [2:0] OP_SUB_BA = 3'b101;
    localparam logic [2:0] OP_ABS_A  = 3'b110;

endpackage

// File: rtl/calc_acc_sequencer_calc.sv
// CombCalc: combinational add/sub/abs on two W-bit two's complement operands with signed overflow flag.
module CombCalc #(
    parameter int W = 16
) (
    input  logic [2:0]   OP,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] R,
    output logic         ovf
);

    logic [W-1:0] x, y, absIn, sum;

    // OP[2] swaps the operand roles, so B+A / B-A / |A| reuse the same adder and abs path
    assign x     = OP[2] ? B : A;
    assign y     = OP[2] ? A : B;
    assign absIn = OP[2] ? A : B;
    assign sum   = OP[0] ? x - y : x + y;

    assign R   = OP[1] ? (absIn[W-1] ? -absIn : absIn) : sum;
    assign ovf = OP[1] ? (absIn == {1'b1, {(W-1){1'b0}}}) :
                 OP[0] ? (x[W-1] != y[W-1]) && (sum[W-1] != x[W-1]) :
                         (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);

endmodule

// File: rtl/calc_acc_sequencer.sv
// calc_acc_sequencer: valid/ready command front-end keeping a signed accumulator fed through CombCalc.
module calc_acc_sequencer
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic         in_load,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_acc,
    output logic         out_ovf,
    output logic         sticky_ovf,
    input  logic         clr_sticky
);

    state_t       state, stateNext;
    logic [2:0]   opQ;
    logic         loadQ, ovfQ, outValidQ, stickyQ;
    logic [W-1:0] dataQ, acc, calcR;
    logic         calcOvf;

    CombCalc #(.W(W)) u_calc (
        .OP  (opQ),
        .A   (acc),
        .B   (dataQ),
        .R   (calcR),
        .ovf (calcOvf)
    );

    always_comb begin
        stateNext = IDLE;
        case (state)
            IDLE:    stateNext = in_valid ? EXEC : IDLE;
            EXEC:    stateNext = RESP;
            RESP:    stateNext = out_ready ? IDLE : RESP;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opQ       <= '0;
            loadQ     <= 1'b0;
            dataQ     <= '0;
            acc       <= '0;
            ovfQ      <= 1'b0;
            outValidQ <= 1'b0;
            stickyQ   <= 1'b0;
        end else begin
            state     <= stateNext;
            outValidQ <= (stateNext == RESP);
            if (state == IDLE && in_valid) begin
                opQ   <= in_op;
                loadQ <= in_load;
                dataQ <= in_data;
            end
            if (state == EXEC) begin
                acc  <= loadQ ? dataQ : calcR;
                ovfQ <= !loadQ && calcOvf;
            end
            // a new overflow beats a simultaneous clear so no event is lost
            if (state == EXEC && !loadQ && calcOvf)
                stickyQ <= 1'b1;
            else if (clr_sticky)
                stickyQ <= 1'b0;
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = outValidQ;
    assign out_acc    = acc;
    assign out_ovf    = ovfQ;
    assign sticky_ovf = stickyQ;

endmodule

// File: tb/tb_calc_acc_sequencer.sv
// tb_calc_acc_sequencer: directed and randomized command sequences checked against an integer reference model.
module tb_calc_acc_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_op = 3'd0;
    logic         in_load = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_acc;
    logic         out_ovf;
    logic         sticky_ovf;
    logic         clr_sticky = 1'b0;

    int tests = 0;
    int failed = 0;

    logic [W-1:0] mAcc = '0;
    logic         mOvf = 1'b0;
    logic         mSticky = 1'b0;

    calc_acc_sequencer #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_load    (in_load),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_ovf    (out_ovf),
        .sticky_ovf (sticky_ovf),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference: signed integer arithmetic, overflow = result outside the W-bit signed range
    task automatic model(input logic ld, input logic [2:0] op, input logic [W-1:0] data, input logic clr);
        int a, b, r;
        a = $signed(mAcc);
        b = $signed(data);
        if (ld) r = b;
        else case (op)
            3'd0:       r = a + b;
            3'd1:       r = a - b;
            3'd2, 3'd3: r = (b < 0) ? -b : b;
            3'd4:       r = b + a;
            3'd5:       r = b - a;
            default:    r = (a < 0) ? -a : a;
        endcase
        mOvf = !ld && (r > 32767 || r < -32768);
        mAcc = r[W-1:0];
        if (mOvf) mSticky = 1'b1;
        else if (clr) mSticky = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doCmd(input logic ld, input logic [2:0] op, input logic [W-1:0] data,
                         input int stall, input logic clrInExec);
        logic [W-1:0] holdAcc;
        logic         holdOvf;
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_load  = ld;
        in_op    = op;
        in_data  = data;
        step();
        in_valid   = 1'b0;
        in_data    = W'($urandom);
        clr_sticky = clrInExec;
        chk("exec_out_valid", out_valid, 0);
        chk("exec_in_ready", in_ready, 0);
        model(ld, op, data, clrInExec);
        step();
        clr_sticky = 1'b0;
        chk("resp_out_valid", out_valid, 1);
        chk("resp_out_acc", out_acc, mAcc);
        chk("resp_out_ovf", out_ovf, mOvf);
        chk("resp_sticky", sticky_ovf, mSticky);
        holdAcc = out_acc;
        holdOvf = out_ovf;
        for (int i = 0; i < stall; i++) begin
            in_valid = $urandom_range(0, 1) != 0;
            in_data  = W'($urandom);
            step();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_acc", out_acc, holdAcc);
            chk("stall_out_ovf", out_ovf, holdOvf);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("done_out_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
    endtask

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_sticky", sticky_ovf, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        doCmd(1'b1, 3'd0, 16'h0005, 0, 1'b0);
        doCmd(1'b0, 3'd0, 16'h0003, 0, 1'b0);
        chk("add_result", out_acc, 16'h0008);

        doCmd(1'b1, 3'd0, 16'h7FFF, 0, 1'b0);
        doCmd(1'b0, 3'd0, 16'h0001, 0, 1'b0);
        chk("ovf_acc", out_acc, 16'h8000);
        chk("ovf_sticky", sticky_ovf, 1);
        doCmd(1'b0, 3'd1, 16'h0000, 0, 1'b0);
        chk("sticky_holds", sticky_ovf, 1);

        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        mSticky = 1'b0;
        chk("sticky_cleared", sticky_ovf, 0);
        doCmd(1'b0, 3'd1, 16'h0001, 0, 1'b1);
        chk("set_beats_clear", sticky_ovf, 1);

        doCmd(1'b1, 3'd0, 16'h0003, 0, 1'b0);
        doCmd(1'b0, 3'd5, 16'h000A, 0, 1'b0);
        chk("sub_ba", out_acc, 16'h0007);
        doCmd(1'b1, 3'd0, 16'hFFF9, 0, 1'b0);
        doCmd(1'b0, 3'd6, 16'h1234, 0, 1'b0);
        chk("abs_a", out_acc, 16'h0007);
        doCmd(1'b0, 3'd3, 16'hFFFE, 0, 1'b0);
        chk("abs_b", out_acc, 16'h0002);

        doCmd(1'b0, 3'd0, 16'h0010, 5, 1'b0);

        // abandon a command mid-flight with reset
        in_valid = 1'b1;
        in_load  = 1'b0;
        in_op    = 3'd0;
        in_data  = 16'h0100;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        mAcc = '0;
        mSticky = 1'b0;
        chk("rstx_out_acc", out_acc, 0);
        chk("rstx_out_valid", out_valid, 0);
        chk("rstx_sticky", sticky_ovf, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstx_no_valid", out_valid, 0);
            chk("rstx_in_ready", in_ready, 1);
        end
        doCmd(1'b0, 3'd0, 16'h0004, 0, 1'b0);
        chk("post_rst_add", out_acc, 16'h0004);

        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] d;
            case ($urandom_range(0, 4))
                0:       d = 16'h8000;
                1:       d = 16'h7FFF;
                default: d = W'($urandom);
            endcase
            doCmd($urandom_range(0, 3) == 0, 3'($urandom), d, $urandom_range(0, 3),
                  $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) begin
                clr_sticky = 1'b1;
                step();
                clr_sticky = 1'b0;
                mSticky = 1'b0;
                chk("rand_clr", sticky_ovf, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
